// File: rtl/pipeline_stage_reg_pkg.sv
// Shared definitions for the pipeline stage register: occupancy state encoding
// and the default bubble (NOP) fill pattern.
package pipeline_stage_reg_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_BUSY  = 2'd1,
    ST_FULL  = 2'd2
  } stage_state_e;

  localparam int   DEFAULT_WIDTH = 22;
  localparam logic NOP_FILL      = 1'b0;

  // Number of held entries for a given state; unknown encodings report empty.
  function automatic logic [1:0] state_occupancy(input stage_state_e st);
    logic [1:0] occ;
    case (st)
      ST_EMPTY: occ = 2'd0;
      ST_BUSY:  occ = 2'd1;
      ST_FULL:  occ = 2'd2;
      default:  occ = 2'd0;
    endcase
    return occ;
  endfunction

endpackage

// File: rtl/pipeline_stage_reg.sv
// Two-entry skid register between pipeline stages: fully registered handshake,
// bubble payload on out_data whenever nothing valid is held.
module pipeline_stage_reg
  import pipeline_stage_reg_pkg::*;
#(
  parameter int               WIDTH     = DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0] NOP_VALUE = {WIDTH{NOP_FILL}}
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy
);

  stage_state_e     state_r;
  stage_state_e     state_nxt_s;
  logic [WIDTH-1:0] main_r;
  logic [WIDTH-1:0] main_nxt_s;
  logic [WIDTH-1:0] skid_r;
  logic [WIDTH-1:0] skid_nxt_s;
  logic             in_ready_r;
  logic             out_valid_r;
  logic [1:0]       occupancy_r;
  logic             in_xfer_s;
  logic             out_xfer_s;

  // Handshakes are qualified with our own registered flags, so stray valids
  // while FULL (or readies while EMPTY) cannot disturb the held entries.
  assign in_xfer_s  = in_valid & in_ready_r;
  assign out_xfer_s = out_ready & out_valid_r;

  // Next-state and entry update for the skid register.
  always_comb begin
    state_nxt_s = state_r;
    main_nxt_s  = main_r;
    skid_nxt_s  = skid_r;
    case (state_r)
      ST_EMPTY: begin
        if (in_xfer_s) begin
          state_nxt_s = ST_BUSY;
          main_nxt_s  = in_data;
        end else begin
          state_nxt_s = ST_EMPTY;
        end
      end
      ST_BUSY: begin
        if (in_xfer_s && out_xfer_s) begin
          state_nxt_s = ST_BUSY;
          main_nxt_s  = in_data;
        end else if (in_xfer_s) begin
          state_nxt_s = ST_FULL;
          skid_nxt_s  = in_data;
        end else if (out_xfer_s) begin
          state_nxt_s = ST_EMPTY;
          main_nxt_s  = NOP_VALUE;
        end else begin
          state_nxt_s = ST_BUSY;
        end
      end
      ST_FULL: begin
        if (out_xfer_s) begin
          state_nxt_s = ST_BUSY;
          main_nxt_s  = skid_r;
          skid_nxt_s  = NOP_VALUE;
        end else begin
          state_nxt_s = ST_FULL;
        end
      end
      default: begin
        state_nxt_s = ST_EMPTY;
        main_nxt_s  = NOP_VALUE;
        skid_nxt_s  = NOP_VALUE;
      end
    endcase
  end

  // State, payload and handshake registers; reset outranks flush.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      state_r     <= ST_EMPTY;
      main_r      <= NOP_VALUE;
      skid_r      <= NOP_VALUE;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      occupancy_r <= 2'd0;
    end else begin
      state_r     <= state_nxt_s;
      main_r      <= main_nxt_s;
      skid_r      <= skid_nxt_s;
      in_ready_r  <= (state_nxt_s != ST_FULL);
      out_valid_r <= (state_nxt_s != ST_EMPTY);
      occupancy_r <= state_occupancy(state_nxt_s);
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign out_data  = main_r;
  assign occupancy = occupancy_r;

endmodule
